polvecp_pack: RTL and testbench

- Packer for the encryption path. Converts a vector of mod-p polynomial coefficients held in the 64-bit data RAM into the packed ciphertext bitstring.
- It is the inverse of the BS2POLVECp unpack operation: the 120-word ciphertext it writes unpacks back to the identical coefficients.
- Sits beside the other ComputeCore3 engines on the data-RAM read/write ports. It is launched by the core's command decoder with a level start and a base-address pair, and reports completion on a level done.

---
 rtl/polvecp_pack_if.sv | 25 ++
 rtl/polvecp_pack.sv | 133 +++++++++++++
 tb/tb_polvecp_pack.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/polvecp_pack_if.sv
// Command and data-RAM signal bundle shared by the packer and its driver (core decoder plus RAM).
interface polvecp_pack_if #(
  parameter int ADDR_W = 9
);
  logic              start;
  logic [ADDR_W-1:0] src_base;
  logic [ADDR_W-1:0] dst_base;
  logic [ADDR_W-1:0] rd_addr;
  logic [63:0]       rd_data;
  logic [ADDR_W-1:0] wr_addr;
  logic [63:0]       wr_data;
  logic              wr_en;
  logic              busy;
  logic              done;

  modport master (
    output start, src_base, dst_base, rd_data,
    input  rd_addr, wr_addr, wr_data, wr_en, busy, done
  );

  modport slave (
    input  start, src_base, dst_base, rd_data,
    output rd_addr, wr_addr, wr_data, wr_en, busy, done
  );
endinterface

// File: rtl/polvecp_pack.sv
// Packs EP-bit coefficients (4 per 64-bit word) into an LSB-first bitstream of 64-bit words.
// Launch to done = NUM_SRC_WORDS+3 cycles; never stalls, since append and emit share one cycle.
module polvecp_pack #(
  parameter int NUM_SRC_WORDS = 192,
  parameter int EP            = 10,
  parameter int ADDR_W        = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  polvecp_pack_if.slave bus
);
  localparam int CW    = 4 * EP;
  localparam int ACC_W = 64 + CW;
  localparam int CNT_W = $clog2(ACC_W + 1);
  localparam int K_W   = $clog2(NUM_SRC_WORDS + 1);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_FLUSH, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, dst_q, rd_addr_q, wr_addr_q, w_q;
  logic [K_W-1:0]    k_q;
  logic              issue_q, vld_q, wr_en_q;
  logic [63:0]       wr_data_q;
  logic [ACC_W-1:0]  acc_q, merged;
  logic [CNT_W-1:0]  cnt_q, cnt_sum;
  logic [CW-1:0]     lanes;
  logic              unused_rd_bits;

  assign unused_rd_bits = ^bus.rd_data;

  always_comb begin
    lanes = '0;
    for (int j = 0; j < 4; j++) begin
      lanes[j*EP +: EP] = bus.rd_data[16*j +: EP];
    end
  end

  assign merged  = acc_q | (ACC_W'(lanes) << cnt_q);
  assign cnt_sum = cnt_q + CNT_W'(CW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_READ;
      S_READ:  if (k_q == K_W'(NUM_SRC_WORDS - 1)) state_d = S_WAIT;
      // Leave once the last returning word is being absorbed this cycle.
      S_WAIT:  if (vld_q && !issue_q) state_d = S_FLUSH;
      S_FLUSH: state_d = S_DONE;
      S_DONE:  if (!bus.start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q     <= '0;
      dst_q     <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      w_q       <= '0;
      k_q       <= '0;
      issue_q   <= 1'b0;
      vld_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
    end else begin
      wr_en_q <= 1'b0;
      issue_q <= 1'b0;
      vld_q   <= issue_q;

      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            src_q <= bus.src_base;
            dst_q <= bus.dst_base;
            k_q   <= '0;
            w_q   <= '0;
            cnt_q <= '0;
            acc_q <= '0;
          end
        end
        S_READ: begin
          rd_addr_q <= src_q + ADDR_W'(k_q);
          issue_q   <= 1'b1;
          k_q       <= k_q + 1'b1;
        end
        S_FLUSH: begin
          // Bits above cnt are already zero, so the tail word is naturally padded.
          if (cnt_q != '0) begin
            wr_data_q <= acc_q[63:0];
            wr_addr_q <= dst_q + w_q;
            wr_en_q   <= 1'b1;
            w_q       <= w_q + 1'b1;
            cnt_q     <= '0;
            acc_q     <= '0;
          end
        end
        default: ;
      endcase

      if (vld_q) begin
        if (cnt_sum >= CNT_W'(64)) begin
          wr_data_q <= merged[63:0];
          wr_addr_q <= dst_q + w_q;
          wr_en_q   <= 1'b1;
          w_q       <= w_q + 1'b1;
          acc_q     <= merged >> 64;
          cnt_q     <= cnt_sum - CNT_W'(64);
        end else begin
          acc_q <= merged;
          cnt_q <= cnt_sum;
        end
      end
    end
  end

  assign bus.rd_addr = rd_addr_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.busy    = (state_q == S_READ) || (state_q == S_WAIT) || (state_q == S_FLUSH);
  assign bus.done    = (state_q == S_DONE);
endmodule

// File: tb/tb_polvecp_pack.sv
// Bench for polvecp_pack: RAM model, bit-stream reference model, per-write compare process.
module tb_polvecp_pack;
  localparam int EP    = 10;
  localparam int NSW   = 192;
  localparam int AW    = 9;
  localparam int DEPTH = 512;
  localparam int NCOEF = 4 * NSW;
  localparam int NEXP  = (NCOEF * EP + 63) / 64;
  localparam logic [15:0] CMASK = 16'((1 << EP) - 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  polvecp_pack_if #(.ADDR_W(AW)) bus ();

  polvecp_pack #(.NUM_SRC_WORDS(NSW), .EP(EP), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [63:0] mem       [DEPTH];
  logic [63:0] wmem      [DEPTH];
  logic [63:0] exp_words [NEXP];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int c0 = 0;
  int widx = 0;
  int last_wr_edge = -1;
  int exp_dst = 0;
  bit exp_active = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.rd_data <= mem[bus.rd_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] coef(input int src, input int n);
    logic [63:0] w;
    w = mem[(src + n / 4) % DEPTH] >> (16 * (n % 4));
    return w[15:0] & CMASK;
  endfunction

  // Reference: stream bit i belongs to coefficient i/EP, bit i%EP.
  task automatic build_model(input int src);
    logic [63:0] wv;
    logic [15:0] c;
    int idx;
    int n;
    for (int i = 0; i < NEXP; i++) begin
      wv = '0;
      for (int b = 0; b < 64; b++) begin
        idx = 64 * i + b;
        n = idx / EP;
        if (n < NCOEF) begin
          c = coef(src, n);
          wv[b] = c[idx % EP];
        end
      end
      exp_words[i] = wv;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.wr_en) begin
      if (!exp_active || widx >= NEXP) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_wr: got write addr %0d data %h, required no write", bus.wr_addr, bus.wr_data);
      end else begin
        chk("wr_addr", 64'(bus.wr_addr), 64'((exp_dst + widx) % DEPTH));
        chk("wr_data", bus.wr_data, exp_words[widx]);
        wmem[bus.wr_addr] = bus.wr_data;
        widx++;
        last_wr_edge = cyc - c0;
      end
    end
  end

  task automatic start_op(input int src, input int dst);
    build_model(src);
    for (int i = 0; i < DEPTH; i++) wmem[i] = '0;
    widx = 0;
    last_wr_edge = -1;
    exp_dst = dst;
    @(negedge clk);
    exp_active = 1'b1;
    bus.src_base = AW'(src);
    bus.dst_base = AW'(dst);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    c0 = cyc;
    chk("busy_after_start", 64'(bus.busy), 64'd1);
  endtask

  task automatic finish_op();
    int done_edge;
    done_edge = -1;
    for (int i = 0; i < 400 && done_edge < 0; i++) begin
      if (bus.done) done_edge = cyc - c0;
      else @(negedge clk);
    end
    if (done_edge < 0) $display("FAIL done_timeout: got no done within 400 cycles, required done");
    chk("done_edge", 64'(done_edge), 64'd195);
    chk("busy_at_done", 64'(bus.busy), 64'd0);
    chk("write_count", 64'(widx), 64'(NEXP));
    chk("last_wr_edge", 64'(last_wr_edge), 64'd194);
    repeat (3) @(negedge clk);
    chk("done_held", 64'(bus.done), 64'd1);
    chk("no_relaunch", 64'(bus.busy), 64'd0);
    bus.start = 1'b0;
    @(negedge clk);
    chk("done_fall", 64'(bus.done), 64'd0);
    exp_active = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_addr"}, 64'(bus.rd_addr), 64'd0);
    chk({tag, "_wr_addr"}, 64'(bus.wr_addr), 64'd0);
    chk({tag, "_wr_data"}, bus.wr_data, 64'd0);
    chk({tag, "_wr_en"}, 64'(bus.wr_en), 64'd0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_done"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    logic [63:0] orv;
    logic [15:0] val;
    logic [63:0] wd;
    int idx;
    int bad;

    bus.start = 1'b0;
    bus.src_base = '0;
    bus.dst_base = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // All coefficients at full scale.
    for (int i = 0; i < DEPTH; i++) mem[i] = 64'h03FF_03FF_03FF_03FF;
    start_op(0, 0);
    finish_op();
    chk("ones_word0", wmem[0], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("ones_word119", wmem[119], 64'hFFFF_FFFF_FFFF_FFFF);

    // Bits above EP must be ignored.
    for (int i = 0; i < DEPTH; i++) mem[i] = 64'hFFFF_FFFF_FFFF_FFFF;
    start_op(0, 0);
    finish_op();
    chk("upper_ignored_word37", wmem[37], 64'hFFFF_FFFF_FFFF_FFFF);

    // Coefficient 6 straddles the first word boundary (stream bits 60..69).
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    mem[1] = 64'h0000_03FF_0000_0000;
    start_op(0, 0);
    finish_op();
    chk("split_word0", wmem[0], 64'hF000_0000_0000_0000);
    chk("split_word1", wmem[1], 64'h0000_0000_0000_003F);
    orv = '0;
    for (int i = 2; i < NEXP; i++) orv = orv | wmem[i];
    chk("split_rest_zero", orv, 64'd0);

    // Ramp at src 200, then unpack the written words and compare to the originals.
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    for (int n = 0; n < NCOEF; n++) begin
      wd = mem[200 + n / 4];
      wd[16 * (n % 4) +: 16] = 16'(n % 1024);
      mem[200 + n / 4] = wd;
    end
    start_op(200, 0);
    finish_op();
    bad = 0;
    for (int n = 0; n < NCOEF; n++) begin
      val = '0;
      for (int b = 0; b < EP; b++) begin
        idx = n * EP + b;
        wd = wmem[idx / 64];
        val[b] = wd[idx % 64];
      end
      if (val != 16'(n % 1024)) bad++;
    end
    chk("roundtrip_bad_coeffs", 64'(bad), 64'd0);

    // Abort by reset at edge 100, then relaunch.
    start_op(0, 0);
    repeat (100) @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.start = 1'b0;
    exp_active = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    start_op(0, 0);
    finish_op();

    // Destination wraps past the top of the address space.
    start_op(0, 450);
    finish_op();
    chk("wrap_word_at_511", wmem[511], exp_words[61]);
    chk("wrap_word_at_0", wmem[0], exp_words[62]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
